// File: rtl/mips_muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Signed operands are reduced to magnitudes at start. The datapath then runs
// unsigned shift-add multiply or restoring division, STEPS_PER_CYCLE radix-2
// steps per clock. Sign correction and the HI/LO write happen in FINISH.
//
// state  | meaning
// IDLE   | waiting; accepts MULT/DIV starts and performs MTHI/MTLO
// RUN    | iterating, cnt_q counts N down to 1
// FINISH | sign correction, HI/LO write, done pulse
module mips_muldiv_unit #(
    parameter int WIDTH           = 32,
    parameter int STEPS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int N  = WIDTH / STEPS_PER_CYCLE;
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FINISH} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH:0]     acc_q, acc_d;       // multiply high half / division remainder
    logic [WIDTH-1:0]   qr_q, qr_d;         // multiplier bits / quotient bits
    logic [WIDTH-1:0]   m_q, m_d;           // multiplicand / divisor magnitude
    logic               is_div_q, is_div_d;
    logic               neg_res_q, neg_res_d;
    logic               neg_rem_q, neg_rem_d;
    logic               zero_q, zero_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic               busy_q, busy_d, done_q, done_d, flag_q, flag_d;

    logic               accept_md, accept_mv, signed_op, a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag, qr_t, quo, rem;
    logic [WIDTH:0]     acc_t, diff_t;
    logic [2*WIDTH-1:0] prod, prod_s;

    // Next-state, iteration datapath and result formatting.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        qr_d      = qr_q;
        m_d       = m_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        zero_d    = zero_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        flag_d    = 1'b0;

        accept_md = start && !cancel && (op <= 3'd3);
        accept_mv = start && !cancel && (op == 3'd4 || op == 3'd5);
        signed_op = !op[0];
        a_neg     = signed_op && operand_a[WIDTH-1];
        b_neg     = signed_op && operand_b[WIDTH-1];
        a_mag     = a_neg ? -operand_a : operand_a;
        b_mag     = b_neg ? -operand_b : operand_b;

        acc_t  = acc_q;
        qr_t   = qr_q;
        diff_t = '0;
        for (int s = 0; s < STEPS_PER_CYCLE; s++) begin
            if (is_div_q) begin
                acc_t  = {acc_t[WIDTH-1:0], qr_t[WIDTH-1]};
                qr_t   = {qr_t[WIDTH-2:0], 1'b0};
                diff_t = acc_t - {1'b0, m_q};
                if (!diff_t[WIDTH]) begin
                    acc_t   = diff_t;
                    qr_t[0] = 1'b1;
                end
            end else begin
                if (qr_t[0]) begin
                    acc_t = acc_t + {1'b0, m_q};
                end
                qr_t  = {acc_t[0], qr_t[WIDTH-1:1]};
                acc_t = acc_t >> 1;
            end
        end

        prod   = {acc_q[WIDTH-1:0], qr_q};
        prod_s = neg_res_q ? -prod : prod;
        quo    = zero_q ? '1 : (neg_res_q ? -qr_q : qr_q);
        rem    = neg_rem_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];

        unique case (state_q)
            S_IDLE: begin
                if (accept_md) begin
                    state_d   = S_RUN;
                    cnt_d     = CW'(N);
                    acc_d     = '0;
                    is_div_d  = op[1];
                    neg_res_d = a_neg ^ b_neg;
                    neg_rem_d = op[1] && a_neg;
                    zero_d    = op[1] && (operand_b == '0);
                    qr_d      = op[1] ? a_mag : b_mag;
                    m_d       = op[1] ? b_mag : a_mag;
                end else if (accept_mv) begin
                    if (op[0]) lo_d = operand_a;
                    else       hi_d = operand_a;
                end
            end
            S_RUN: begin
                if (cancel) begin
                    state_d = S_IDLE;
                end else begin
                    acc_d = acc_t;
                    qr_d  = qr_t;
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) state_d = S_FINISH;
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
                if (!cancel) begin
                    done_d = 1'b1;
                    if (is_div_q) begin
                        hi_d   = rem;
                        lo_d   = quo;
                        flag_d = zero_q;
                    end else begin
                        hi_d = prod_s[2*WIDTH-1:WIDTH];
                        lo_d = prod_s[WIDTH-1:0];
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            qr_q      <= '0;
            m_q       <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            zero_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            flag_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            qr_q      <= qr_d;
            m_q       <= m_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            zero_q    <= zero_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            flag_q    <= flag_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = flag_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Scoreboard bench for mips_muldiv_unit (WIDTH=32, STEPS_PER_CYCLE=1).
module tb_mips_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] operand_a, operand_b;
    logic        cancel;
    logic        busy, done, div_by_zero;
    logic [31:0] hi, lo;

    int errors = 0;
    int checks = 0;
    logic [64:0] sb_q[$];   // {div_by_zero, hi, lo}

    mips_muldiv_unit #(.WIDTH(32), .STEPS_PER_CYCLE(1)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .operand_a(operand_a), .operand_b(operand_b), .cancel(cancel),
        .busy(busy), .done(done), .div_by_zero(div_by_zero),
        .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [64:0] model(input logic [2:0] mop, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, sq, sr;
        logic [63:0] p, uq, ur;
        model = '0;
        case (mop)
            3'd0: begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
                p  = 64'(sa * sb);
                model = {1'b0, p};
            end
            3'd1: begin
                p = {32'd0, a} * {32'd0, b};
                model = {1'b0, p};
            end
            3'd2: begin
                if (b == 32'd0) model = {1'b1, a, 32'hFFFFFFFF};
                else begin
                    sa = longint'($signed(a));
                    sb = longint'($signed(b));
                    sq = sa / sb;
                    sr = sa % sb;
                    model = {1'b0, sr[31:0], sq[31:0]};
                end
            end
            default: begin
                if (b == 32'd0) model = {1'b1, a, 32'hFFFFFFFF};
                else begin
                    uq = {32'd0, a} / {32'd0, b};
                    ur = {32'd0, a} % {32'd0, b};
                    model = {1'b0, ur[31:0], uq[31:0]};
                end
            end
        endcase
    endfunction

    task automatic start_op(input logic [2:0] mop, input logic [31:0] a, input logic [31:0] b);
        start     = 1'b1;
        op        = mop;
        operand_a = a;
        operand_b = b;
        sb_q.push_back(model(mop, a, b));
    endtask

    // Called in cycle 1 of an operation. Optionally injects an ignored start at
    // cycle inj_cyc, and optionally issues a follow-on op in the done cycle.
    task automatic wait_done(input string name, input bit nxt, input logic [2:0] nop,
                             input logic [31:0] na, input logic [31:0] nb, input int inj_cyc);
        int cyc;
        bit got;
        logic [64:0] exp;
        cyc = 1;
        got = 1'b0;
        while (!got && cyc <= 40) begin
            start = 1'b0;
            if (done) begin
                got = 1'b1;
                checks++;
                if (cyc != 34) begin
                    errors++;
                    $display("FAIL %s latency: done in cycle %0d, required 34", name, cyc);
                end
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL %s scoreboard: result with empty queue", name);
                end else begin
                    exp = sb_q.pop_front();
                    if ({div_by_zero, hi, lo} !== exp) begin
                        errors++;
                        $display("FAIL %s result: got flag=%0b hi=%h lo=%h, required flag=%0b hi=%h lo=%h",
                                 name, div_by_zero, hi, lo, exp[64], exp[63:32], exp[31:0]);
                    end
                end
                checks++;
                if (busy !== 1'b0) begin
                    errors++;
                    $display("FAIL %s busy_at_done: got %b, required 0", name, busy);
                end
                if (nxt) start_op(nop, na, nb);
            end else begin
                checks++;
                if (busy !== 1'b1 || div_by_zero !== 1'b0) begin
                    errors++;
                    $display("FAIL %s busy cycle %0d: got busy=%b flag=%b, required busy=1 flag=0",
                             name, cyc, busy, div_by_zero);
                end
                if (cyc == inj_cyc) begin
                    start     = 1'b1;
                    op        = 3'd1;
                    operand_a = 32'h0000_1111;
                    operand_b = 32'h0000_2222;
                end
            end
            tick();
            cyc++;
        end
        start = 1'b0;
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: no done within 40 cycles", name);
        end
    endtask

    task automatic run_op(input string name, input logic [2:0] mop, input logic [31:0] a,
                          input logic [31:0] b, input int inj_cyc);
        start_op(mop, a, b);
        tick();
        wait_done(name, 1'b0, 3'd0, 32'd0, 32'd0, inj_cyc);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || div_by_zero !== 1'b0) begin
            errors++;
            $display("FAIL %s after_done: got busy=%b done=%b flag=%b, required 0 0 0",
                     name, busy, done, div_by_zero);
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({busy, done, div_by_zero} !== 3'b000 || hi !== 32'd0 || lo !== 32'd0) begin
            errors++;
            $display("FAIL reset_state: got busy=%b done=%b flag=%b hi=%h lo=%h, required all 0",
                     busy, done, div_by_zero, hi, lo);
        end
    endtask

    task automatic test_multiply();
        run_op("mult_neg", 3'd0, 32'hFFFFFFFF, 32'h00000002, -1);
        run_op("multu", 3'd1, 32'hFFFFFFFF, 32'h00000002, -1);
        run_op("mult_mixed", 3'd0, 32'h80000000, 32'h7FFFFFFF, -1);
    endtask

    task automatic test_divide();
        run_op("div_neg_dividend", 3'd2, 32'hFFFFFFF9, 32'h00000002, -1);
        run_op("div_neg_divisor", 3'd2, 32'h00000007, 32'hFFFFFFFE, -1);
        run_op("divu_small", 3'd3, 32'h00000007, 32'h00000002, -1);
        run_op("divu_large", 3'd3, 32'hFFFFFFFF, 32'h00010000, -1);
        run_op("div_by_zero", 3'd2, 32'h12345678, 32'h00000000, -1);
        run_op("divu_by_zero", 3'd3, 32'h87654321, 32'h00000000, -1);
        run_op("div_min_neg1", 3'd2, 32'h80000000, 32'hFFFFFFFF, -1);
    endtask

    task automatic test_back_to_back();
        start_op(3'd0, 32'h00001234, 32'hFFFF0000);
        tick();
        wait_done("b2b_first", 1'b1, 3'd3, 32'd100, 32'd7, -1);
        wait_done("b2b_second", 1'b0, 3'd0, 32'd0, 32'd0, -1);
    endtask

    task automatic test_ignored();
        logic [31:0] hi_s, lo_s;
        run_op("start_while_busy", 3'd0, 32'h00000064, 32'hFFFFFFFD, 5);
        hi_s = hi;
        lo_s = lo;
        start = 1'b1; op = 3'd0; operand_a = 32'd9; operand_b = 32'd9; cancel = 1'b1;
        tick();
        start = 1'b0; cancel = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL start_with_cancel: got busy=%b, required 0", busy);
        end
        start = 1'b1; op = 3'd6; operand_a = 32'hDEAD0000; operand_b = 32'd3;
        tick();
        start = 1'b1; op = 3'd7;
        tick();
        start = 1'b0;
        checks++;
        if (busy !== 1'b0 || hi !== hi_s || lo !== lo_s) begin
            errors++;
            $display("FAIL op6_op7_ignored: got busy=%b hi=%h lo=%h, required busy=0 hi=%h lo=%h",
                     busy, hi, lo, hi_s, lo_s);
        end
    endtask

    task automatic test_cancel();
        logic [31:0] lo_s;
        int k;
        bit saw;
        start = 1'b1; op = 3'd4; operand_a = 32'hCAFEF00D;
        tick();
        start = 1'b0;
        checks++;
        if (hi !== 32'hCAFEF00D || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL mthi: got hi=%h busy=%b done=%b, required hi=cafef00d busy=0 done=0", hi, busy, done);
        end
        start = 1'b1; op = 3'd5; operand_a = 32'h0BADBEEF;
        tick();
        start = 1'b0;
        checks++;
        if (lo !== 32'h0BADBEEF || hi !== 32'hCAFEF00D || busy !== 1'b0) begin
            errors++;
            $display("FAIL mtlo: got lo=%h hi=%h busy=%b, required lo=0badbeef hi=cafef00d busy=0", lo, hi, busy);
        end
        lo_s = lo;
        for (int t = 0; t < 2; t++) begin
            k = (t == 0) ? 10 : 33;
            start = 1'b1; op = 3'd0; operand_a = 32'd7; operand_b = 32'd9;
            tick();
            start = 1'b0;
            repeat (k - 1) tick();
            cancel = 1'b1;
            tick();
            cancel = 1'b0;
            checks++;
            if (busy !== 1'b0) begin
                errors++;
                $display("FAIL cancel_k%0d busy: got %b, required 0", k, busy);
            end
            saw = 1'b0;
            for (int c = 0; c < 40; c++) begin
                if (done === 1'b1 || busy === 1'b1) saw = 1'b1;
                tick();
            end
            checks++;
            if (saw || hi !== 32'hCAFEF00D || lo !== lo_s) begin
                errors++;
                $display("FAIL cancel_k%0d result: activity=%b hi=%h lo=%h, required activity=0 hi=cafef00d lo=%h",
                         k, saw, hi, lo, lo_s);
            end
        end
    endtask

    task automatic test_async_reset();
        start = 1'b1; op = 3'd0; operand_a = 32'h00010001; operand_b = 32'h00030003;
        tick();
        start = 1'b0;
        repeat (4) tick();
        #3 reset = 1'b0;
        #1;
        checks++;
        if ({busy, done, div_by_zero} !== 3'b000 || hi !== 32'd0 || lo !== 32'd0) begin
            errors++;
            $display("FAIL async_reset: got busy=%b done=%b flag=%b hi=%h lo=%h, required all 0",
                     busy, done, div_by_zero, hi, lo);
        end
        #2 reset = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL after_reset_idle: got busy=%b done=%b, required 0 0", busy, done);
        end
        run_op("mult_after_reset", 3'd0, 32'd3, 32'd5, -1);
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; op = 3'd0;
        operand_a = '0; operand_b = '0; cancel = 1'b0;
        repeat (2) tick();
        test_reset();
        reset = 1'b1;
        tick();
        test_reset();
        test_multiply();
        test_divide();
        test_back_to_back();
        test_ignored();
        test_cancel();
        test_async_reset();
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mips_muldiv_unit.md
# mips_muldiv_unit

Parametrised iterative multiply/divide unit with architectural HI/LO registers for the pipelined MIPS32 core. It sits beside the EX-stage ALU and accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the ID/EX register. It runs multi-cycle operations while holding `busy` so the hazard unit stalls dependent MFHI/MFLO, and it supports cancellation on pipeline flush.

## Interface
- `WIDTH`, 32: operand width and HI/LO width; must be even and at least 8.
- `STEPS_PER_CYCLE`, 1: radix-2 iterations per clock; legal values are 1, 2 and 4, and the value must divide `WIDTH`. Define N = WIDTH/STEPS_PER_CYCLE.
- `clk`  in  1  clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  operation request; sampled only in IDLE.
- `op`  in  3  operation code: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; codes 6 and 7 are ignored.
- `operand_a`  in  WIDTH  rs value (multiplicand, dividend, or MTHI/MTLO source).
- `operand_b`  in  WIDTH  rt value (multiplier or divisor).
- `cancel`  in  1  flush; aborts any operation in progress.
- `busy`  out  1  high while a MULT/DIV is in flight.
- `done`  out  1  one-cycle pulse when HI/LO take a MULT/DIV result.
- `div_by_zero`  out  1  valid only with `done`; high when a DIV/DIVU had divisor 0.
- `hi`  out  WIDTH  HI register.
- `lo`  out  WIDTH  LO register.

## Operation
- **States.**
  - IDLE: accepts `start`.
  - RUN: iterates; an iteration counter counts N down to 0.
  - FINISH: sign correction, HI/LO write and `done`.
- **Transitions.**
  - IDLE→RUN on `start` with op 0–3 and `cancel`=0.
  - RUN→FINISH after N RUN cycles.
  - FINISH→IDLE unconditionally.
  - Any state→IDLE on `cancel` (RUN/FINISH) or on `reset`.
- **Operand capture.** Operands and op are latched on the accepting edge; later input changes have no effect.
  - Signed ops: magnitudes are latched, and result sign flags are computed at start.
- **Multiply.** {hi,lo} = full 2·WIDTH-bit product; signed for MULT, unsigned for MULTU.
- **Divide.**
  - lo = quotient truncated toward zero; hi = remainder, whose sign follows the dividend.
  - Divisor 0: lo = all ones, hi = operand_a, and `div_by_zero`=1 with `done`. No trap is raised.
  - DIV of MIN by −1: lo = MIN (100…0), hi = 0, no flag.
- **MTHI/MTLO.** Single-cycle in IDLE: hi or lo is written on the accepting edge. The FSM stays IDLE and asserts neither `busy` nor `done`.
- **Ignored requests.**
  - `start` is ignored when `busy`=1.
  - `start` with op 6 or 7 is ignored.
  - `start` together with `cancel`=1 in IDLE is ignored, because `cancel` has priority.
- **Cancel.** `cancel` in RUN or FINISH returns the FSM to IDLE. HI/LO are not written and `done` is not pulsed.
- **Reset values.** hi=0, lo=0, busy=0, done=0, div_by_zero=0, state IDLE.
  - Reset asserted mid-operation aborts it immediately (asynchronous), with no result write.

## Timing
- **MULT/DIV latency.** Take the cycle in which `start` is sampled as cycle 0.
  - `busy`=1 in cycles 1..N+1.
  - In cycle N+2: `done`=1, `busy`=0, and hi/lo show the new result.
  - For WIDTH=32 and STEPS_PER_CYCLE=1, `done` occurs in cycle 34.
- **Back-to-back.** `start` in the `done` cycle is accepted, so `busy` is high again in the next cycle; throughput is one operation per N+2 cycles.
- **Move latency.** MTHI/MTLO take effect in cycle 1. The same edge may also accept nothing else.
- **Output registration.** `busy`, `done`, `div_by_zero`, `hi` and `lo` are all registered; there is no combinational path from the inputs to any output.
- **Cancel timing.** `cancel` sampled in cycle k (1 ≤ k ≤ N+1) gives `busy`=0 in cycle k+1. `cancel` in IDLE has no effect other than blocking `start`.
- **`div_by_zero`.** It is 0 in every cycle in which `done`=0.

## Test plan
All scenarios use WIDTH=32 and STEPS_PER_CYCLE=1.
- **Multiply.**
  - MULT 0xFFFFFFFF×0x00000002 → `done` in cycle 34, hi=0xFFFFFFFF, lo=0xFFFFFFFE, `busy` high in cycles 1–33.
  - MULTU with the same operands → hi=0x00000001, lo=0xFFFFFFFE.
- **Divide signs.**
  - DIV 0xFFFFFFF9 (−7) ÷ 2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - DIV 7 ÷ 0xFFFFFFFE (−2) → lo=0xFFFFFFFD, hi=0x00000001.
  - DIVU 7 ÷ 2 → lo=3, hi=1.
- **Divide corners.**
  - DIV 0x12345678 ÷ 0 → lo=0xFFFFFFFF, hi=0x12345678, `div_by_zero`=1 only in the `done` cycle.
  - DIV 0x80000000 ÷ 0xFFFFFFFF → lo=0x80000000, hi=0, flag 0.
- **Cancel and back-to-back.**
  - Preload MTHI 0xCAFEF00D (hi updates in cycle 1, `busy` stays 0). Then start a MULT and assert `cancel` in cycle 10 → `busy`=0 in cycle 11, hi remains 0xCAFEF00D, no `done`.
  - Start DIVU 100÷7 in the `done` cycle of a prior MULT → accepted, and the second `done` comes 34 cycles later with lo=14, hi=2.
- **Ignored starts.**
  - `start` during `busy` → ignored, and the first result is unchanged.
  - `start` together with `cancel` in IDLE → `busy` stays 0.
- **Reset.** `reset` driven low asynchronously in cycle 5 of a MULT (between edges) → outputs go to 0 immediately. After release, the unit is in IDLE and the next MULT 3×5 gives lo=15, hi=0.
